c3lib_vecsync_tx_queue: RTL
===========================

# c3lib_vecsync_tx_queue

Write-side (wr_clk) transmit front end for the C3 handshake vector synchronizer. It accepts vectors from a valid/ready producer into a small FIFO and drains them one at a time into the synchronizer's load/ready-to-load port. It never loads while a crossing is in flight. An optional watchdog flags a handshake that stalls.

## Interface
Parameters:
- DWIDTH, 1, width of each vector.
- DEPTH, 4, number of FIFO entries; power of 2, minimum 2.
- RESET_VAL, 0, FIFO storage and sync_data_in reset to all-0 if 0, all-1 otherwise.
- TIMEOUT_CYC, 1024, watchdog threshold in wr_clk cycles; range 2..65535.

Ports:
- wr_clk  in  1  write-domain clock.
- wr_rst_n  in  1  reset; asynchronous, active-low.
- in_data  in  DWIDTH  producer vector.
- in_vld  in  1  producer valid.
- in_rdy  out  1  queue can accept; in_rdy = !full.
- flush  in  1  synchronous; empties the FIFO.
- sync_data_in  out  DWIDTH  FIFO head, driven to the synchronizer's data_in.
- sync_load  out  1  load strobe to the synchronizer's load_data_in.
- sync_rdy2ld  in  1  from the synchronizer's data_in_rdy2ld.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- stall_err  out  1  sticky watchdog error.
- err_clr  in  1  synchronous; clears stall_err.

## Operation
- Push: in_vld & in_rdy writes in_data at wptr. Pop: sync_load.
- Read and write pointers are $clog2(DEPTH)+1 bits, with the MSB as the wrap bit.
  - Empty when the pointers are equal.
  - Full when the MSBs differ and the remaining bits are equal.
  - level = wptr - rptr, modulo 2^($clog2(DEPTH)+1).
- sync_load = !empty & sync_rdy2ld & !flush. This output is combinational.
- sync_data_in is driven from registered storage and equals mem[rptr], so it is stable whenever sync_load is high.
- The synchronizer deasserts rdy2ld one cycle after a load. This guarantees at most one load per crossing. The queue adds no extra gap.
- Simultaneous push and pop:
  - Both are allowed when not full; level is unchanged.
  - When full, in_rdy=0, so no push occurs even if a pop occurs in the same cycle. There is no pass-through.
- Flush:
  - Sets rptr := wptr in the same cycle and suppresses both sync_load and push.
  - A crossing already loaded into the synchronizer completes normally.
- Reset values:
  - Pointers 0, level 0, in_rdy 1, sync_load 0, stall_err 0.
  - Storage and sync_data_in = {DWIDTH{RESET_VAL bit}}.
- Mid-operation reset: all queued data is discarded.
  - wr_rst_n also resets the synchronizer's write side, so sync_rdy2ld returns to 1.
  - The queue restarts empty.
- Watchdog state machine (only when compiled in):
  - IDLE -> WAIT on sync_load.
  - WAIT -> IDLE when sync_rdy2ld=1.
  - In WAIT, a 16-bit counter increments each cycle. At count == TIMEOUT_CYC-1 it sets stall_err and saturates.
  - stall_err stays set until err_clr; err_clr takes priority over a same-cycle set.
  - flush does not affect the watchdog.

## Timing
- Push to earliest sync_load: 1 cycle, i.e. push in cycle N, load in N+1 if sync_rdy2ld=1.
- Back-to-back loads are paced entirely by the synchronizer round trip. The queue adds zero cycles beyond sync_rdy2ld.
- in_rdy updates in the cycle after the push that fills the FIFO.
- stall_err asserts in the cycle after the counter reaches TIMEOUT_CYC-1. That is TIMEOUT_CYC cycles after entering WAIT.

## Configuration
- Macro C3LIB_VECSYNC_TX_WDOG_EN.
- Defined: the watchdog state machine, counter and sticky stall_err are built as described above.
- Undefined: no watchdog logic is built. stall_err is tied to 0, err_clr is ignored and TIMEOUT_CYC is unused.

## Structure
- Shared package c3lib_vecsync_pkg holds:
  - the watchdog state enum (WDOG_IDLE, WDOG_WAIT);
  - the watchdog counter width constant (16);
  - the pointer-width helper function.
- One sub-module, c3lib_vecsync_tx_fifo, provides storage, pointers, full/empty and level.
- The top level holds the load control, flush gating and watchdog.

## Test plan
- Reset, then push 0x3 with rdy2ld=1 -> sync_load in the next cycle with sync_data_in=0x3; level goes 1 -> 0.
- DEPTH=4, hold rdy2ld=0, push 5 vectors -> 4 accepted, in_rdy=0, level=4; release rdy2ld -> vectors drain in order.
- Full FIFO with same-cycle pop and in_vld=1 -> no push that cycle, level=3, in_rdy=1 in the next cycle.
- Flush with 3 entries queued and one crossing in flight -> level=0, no sync_load; the in-flight crossing completes at the far end.
- WDOG_EN defined, TIMEOUT_CYC=8, hold rdy2ld=0 after a load -> stall_err=1 eight cycles later; err_clr -> 0.
- Assert wr_rst_n low mid-drain -> all outputs return to their reset values within the same cycle (asynchronous reset); after release, the queue is empty.

Source files
------------

// File: rtl/c3lib_vecsync_pkg.sv
// Shared definitions for the C3 handshake vector synchronizer transmit front end.
// Contains the watchdog state encoding, the watchdog counter width and a
// pointer-width helper used by the FIFO and the top level.
package c3lib_vecsync_pkg;

  typedef enum logic {
    WDOG_IDLE = 1'b0,
    WDOG_WAIT = 1'b1
  } wdog_state_e;

  localparam int WDOG_CNT_W = 16;

  // Read/write pointers carry one extra wrap bit above the entry index.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/c3lib_vecsync_tx_fifo.sv
// Storage, wrap-bit pointers, full/empty and occupancy for the vecsync transmit
// queue. Push and pop are already qualified by the caller; flush snaps the read
// pointer onto the write pointer and takes priority over both.
module c3lib_vecsync_tx_fifo
  import c3lib_vecsync_pkg::*;
#(
  parameter int DWIDTH    = 1,
  parameter int DEPTH     = 4,
  parameter int RESET_VAL = 0
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic                          flush,
  input  logic [DWIDTH-1:0]             wdata,
  output logic [DWIDTH-1:0]             rdata,
  output logic                          full,
  output logic                          empty,
  output logic [ptr_width(DEPTH)-1:0]   level
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0]     PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [DWIDTH-1:0] RST_WORD = (RESET_VAL == 0) ? '0 : '1;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;

  // Advance the pointers; flush discards everything queued by catching rptr up.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      rptr <= wptr;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
    end
  end

  // Entry storage, reset to a known pattern so the head output is defined.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RST_WORD;
    end else if (push && !flush) begin
      mem[wptr[AW-1:0]] <= wdata;
    end
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[PW-1] != rptr[PW-1]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level = wptr - rptr;

endmodule

// File: rtl/c3lib_vecsync_tx_queue.sv
// Write-side transmit front end for the C3 handshake vector synchronizer.
// Queues producer vectors and hands the head to the synchronizer whenever it
// reports ready-to-load, so the pacing is set entirely by the crossing.
// Optional stall watchdog is built when C3LIB_VECSYNC_TX_WDOG_EN is defined.
module c3lib_vecsync_tx_queue
  import c3lib_vecsync_pkg::*;
#(
  parameter int DWIDTH      = 1,
  parameter int DEPTH       = 4,
  parameter int RESET_VAL   = 0,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst_n,
  input  logic [DWIDTH-1:0]             in_data,
  input  logic                          in_vld,
  output logic                          in_rdy,
  input  logic                          flush,
  output logic [DWIDTH-1:0]             sync_data_in,
  output logic                          sync_load,
  input  logic                          sync_rdy2ld,
  output logic [ptr_width(DEPTH)-1:0]   level,
  output logic                          stall_err,
  input  logic                          err_clr
);

  logic full;
  logic empty;
  logic push;

  // A full queue refuses input even if it pops this cycle; no pass-through.
  assign in_rdy    = !full;
  assign push      = in_vld && in_rdy && !flush;
  assign sync_load = !empty && sync_rdy2ld && !flush;

  c3lib_vecsync_tx_fifo #(
    .DWIDTH    (DWIDTH),
    .DEPTH     (DEPTH),
    .RESET_VAL (RESET_VAL)
  ) u_fifo (
    .wr_clk   (wr_clk),
    .wr_rst_n (wr_rst_n),
    .push     (push),
    .pop      (sync_load),
    .flush    (flush),
    .wdata    (in_data),
    .rdata    (sync_data_in),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

`ifdef C3LIB_VECSYNC_TX_WDOG_EN

  localparam logic [WDOG_CNT_W-1:0] TO_LIMIT = WDOG_CNT_W'(TIMEOUT_CYC - 1);

  wdog_state_e           wdog_state;
  logic [WDOG_CNT_W-1:0] wdog_cnt;

  // Watchdog: time how long the synchronizer stays not-ready after a load.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wdog_state <= WDOG_IDLE;
      wdog_cnt   <= '0;
      stall_err  <= 1'b0;
    end else begin
      case (wdog_state)
        WDOG_IDLE: begin
          if (sync_load) begin
            wdog_state <= WDOG_WAIT;
            wdog_cnt   <= '0;
          end
        end
        WDOG_WAIT: begin
          if (sync_load) begin
            wdog_cnt <= '0;
          end else if (sync_rdy2ld) begin
            wdog_state <= WDOG_IDLE;
            wdog_cnt   <= '0;
          end else if (wdog_cnt != TO_LIMIT) begin
            wdog_cnt <= wdog_cnt + 1'b1;
          end
        end
        default: begin
          wdog_state <= WDOG_IDLE;
          wdog_cnt   <= '0;
        end
      endcase
      if (err_clr) begin
        stall_err <= 1'b0;
      end else if ((wdog_state == WDOG_WAIT) && !sync_rdy2ld && (wdog_cnt == TO_LIMIT)) begin
        stall_err <= 1'b1;
      end
    end
  end

`else

  logic unused_wdog;
  assign unused_wdog = err_clr ^ (TIMEOUT_CYC > 0);
  assign stall_err   = 1'b0;

`endif

endmodule
